i2c_temp_slave: RTL

I2C target (responder) that emulates the ADT7420 temperature sensor register map for the I2C master.
- Used for closed-loop simulation of the thermometer design, and for board-to-board bring-up where a second FPGA plays the sensor.
- Oversamples SCL/SDA on the 100 MHz system clock.
- Decodes START/STOP, matches its 7-bit address, accepts pointer and config writes, and serves temperature/ID reads.
- Drives SDA open-drain (pull-low enable only).

---
 rtl/i2c_temp_slave.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_temp_slave.sv
// I2C target emulating the ADT7420 register map (temp MSB/LSB, config, ID) with open-drain SDA.
// Latency: pin changes are acted on 3 clk later (2-flop sync + edge flop); SDA output updates on the next clk.
// Backpressure: none; never stretches SCL, follows the master's clock at any rate well below clk/8.
module i2c_temp_slave #(
    parameter logic [6:0] I2C_ADDR   = 7'h4B,
    parameter logic [7:0] ID_VALUE   = 8'hCB,
    parameter logic [7:0] CONFIG_RST = 8'h00
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_value,
    output logic [7:0]  config_reg,
    output logic [7:0]  reg_ptr,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    state_t      state, state_n;
    logic [2:0]  scl_sync, sda_sync;
    logic        scl_lvl, scl_prev, sda_lvl, sda_prev;
    logic        scl_rise, scl_fall, start_evt, stop_evt;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  tx, tx_n;
    logic        rw, rw_n;
    logic        first_byte, first_byte_n;
    logic [15:0] snapshot, snapshot_n;
    logic        sda_oe_n, busy_n;
    logic [7:0]  config_n, ptr_n;
    logic [7:0]  rd_data;

    // Synchronize the pins; [1] is the usable level, [2] the previous level for edge detection.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl_in};
            sda_sync <= {sda_sync[1:0], sda_in};
        end
    end

    assign scl_lvl   = scl_sync[1];
    assign scl_prev  = scl_sync[2];
    assign sda_lvl   = sda_sync[1];
    assign sda_prev  = sda_sync[2];
    assign scl_rise  = scl_lvl & ~scl_prev;
    assign scl_fall  = ~scl_lvl & scl_prev;
    assign start_evt = scl_lvl & scl_prev & sda_prev & ~sda_lvl;
    assign stop_evt  = scl_lvl & scl_prev & ~sda_prev & sda_lvl;

    // Read-side register map; temperature comes from the snapshot so MSB/LSB of one read agree.
    always_comb begin
        rd_data = 8'h00;
        case (reg_ptr)
            8'h00:   rd_data = snapshot[15:8];
            8'h01:   rd_data = snapshot[7:0];
            8'h03:   rd_data = config_reg;
            8'h0B:   rd_data = ID_VALUE;
            default: rd_data = 8'h00;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath updates; START/STOP take priority over everything else.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        tx_n         = tx;
        rw_n         = rw;
        first_byte_n = first_byte;
        snapshot_n   = snapshot;
        sda_oe_n     = sda_oe;
        busy_n       = busy;
        config_n     = config_reg;
        ptr_n        = reg_ptr;
        if (start_evt) begin
            state_n   = ADDR;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (stop_evt) begin
            state_n   = IDLE;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sda_oe_n = 1'b0;
                end
                ADDR: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n   = {shift[6:0], sda_lvl};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_n = 4'd0;
                        if (shift[7:1] == I2C_ADDR) begin
                            sda_oe_n = 1'b1;
                            busy_n   = 1'b1;
                            rw_n     = shift[0];
                            state_n  = ADDR_ACK;
                            if (shift[0]) begin
                                snapshot_n = temp_value;
                            end
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            tx_n      = rd_data;
                            sda_oe_n  = ~rd_data[7];
                            bit_cnt_n = 4'd1;
                            state_n   = RD_BYTE;
                        end else begin
                            sda_oe_n     = 1'b0;
                            first_byte_n = 1'b1;
                            bit_cnt_n    = 4'd0;
                            state_n      = WR_BYTE;
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n   = {shift[6:0], sda_lvl};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_n = 4'd0;
                        sda_oe_n  = 1'b1;
                        state_n   = WR_ACK;
                        if (first_byte) begin
                            ptr_n        = shift;
                            first_byte_n = 1'b0;
                        end else begin
                            // Only config is writable; other addresses are ACKed and dropped.
                            if (reg_ptr == 8'h03) begin
                                config_n = shift;
                            end
                            ptr_n = reg_ptr + 8'd1;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        state_n  = WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    // bit_cnt counts bits already placed on the wire; bit 7 went out on entry.
                    if (scl_fall) begin
                        if (bit_cnt < 4'd8) begin
                            sda_oe_n  = ~tx[6];
                            tx_n      = {tx[6:0], 1'b0};
                            bit_cnt_n = bit_cnt + 4'd1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            ptr_n     = reg_ptr + 8'd1;
                            bit_cnt_n = 4'd0;
                            state_n   = RD_ACK;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_lvl) begin
                        state_n = IGNORE;
                    end else if (scl_fall) begin
                        tx_n      = rd_data;
                        sda_oe_n  = ~rd_data[7];
                        bit_cnt_n = 4'd1;
                        state_n   = RD_BYTE;
                    end
                end
                IGNORE: begin
                    sda_oe_n = 1'b0;
                end
                default: begin
                    state_n  = IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            tx         <= 8'h00;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            snapshot   <= 16'h0000;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            config_reg <= CONFIG_RST;
            reg_ptr    <= 8'h00;
        end else begin
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            tx         <= tx_n;
            rw         <= rw_n;
            first_byte <= first_byte_n;
            snapshot   <= snapshot_n;
            sda_oe     <= sda_oe_n;
            busy       <= busy_n;
            config_reg <= config_n;
            reg_ptr    <= ptr_n;
        end
    end

endmodule
